param_counter: RTL and testbench
================================

# param_counter

Parametrised successor to the single-width enable counter: a modulo-N up/down counter with prescaler, synchronous clear, parallel load, selectable wrap or saturate behaviour, and cascade outputs. It is the general timing and counting primitive for the simulation designs. Instances can be chained through `carry_out` to build wider or multi-digit counters.

## Interface
- `WIDTH`, 8, count register width in bits.
- `MODULUS`, 2**WIDTH, count range is 0..MODULUS-1; legal range 2..2**WIDTH.
- `PRESCALE`, 1, a count step occurs once every PRESCALE enabled cycles; legal range ≥1.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset; 0 resets the block on the next clk edge.
- `enable`  in  1  count enable; also gates the prescaler.
- `clear`  in  1  synchronous clear of count and prescaler.
- `load`  in  1  synchronous parallel load.
- `load_value`  in  WIDTH  value for load.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `saturate`  in  1  1 = hold at the end value, 0 = wrap.
- `count`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal count, combinational: count==MODULUS-1 when up=1, count==0 when up=0.
- `carry_out`  out  1  combinational: tc & enable & tick; cascade enable for the next stage.
- `wrapped`  out  1  registered one-cycle pulse: a step was attempted at terminal count.

## Operation
- Priority per edge: reset (low) > clear > load > step > hold.
- Reset: count=0, prescaler=0, wrapped=0.
- clear=1: count=0, prescaler=0, wrapped=0.
- load=1: count=min(load_value, MODULUS-1), prescaler=0, wrapped=0. Out-of-range loads clamp and do not error.
- tick: the internal prescale strobe. Without PRESCALE>1, tick=enable. Otherwise the prescaler counts 0..PRESCALE-1 only on enabled cycles. tick=enable & (prescaler==PRESCALE-1), and the prescaler returns to 0 on that cycle.
- Step (tick=1, not tc): count ±1.
- Step at tc, saturate=0: wrap. Up goes from MODULUS-1 to 0; down goes from 0 to MODULUS-1. wrapped=1 on the next cycle.
- Step at tc, saturate=1: count holds. wrapped=1 on the next cycle, and repeats each further tick while held.
- enable=0: count and prescaler hold. wrapped=0.
- A direction change takes effect on the next tick. tc follows `up` combinationally.
- Arithmetic: compare against MODULUS-1 explicitly. Do not rely on natural WIDTH overflow, because MODULUS may be less than 2**WIDTH.

## Timing
- Load and clear: value visible on `count` one cycle after the edge where they are sampled.
- Step latency: `count` updates on the edge where tick=1. `wrapped` is high for exactly that following cycle.
- `tc` and `carry_out` are combinational from registers and inputs, with no added latency. A cascaded stage with enable=carry_out steps on the same edge that the lower stage wraps.
- Reset mid-count: the next edge forces all outputs to their reset values regardless of other inputs. Counting resumes on the first edge with reset=1.
- clear and load on the same edge: clear wins and load_value is ignored.
- PRESCALE=4, enable held high: one step every 4 clocks. The first step comes on the 4th enabled edge after reset, clear or load.

## Structure
- Shared package `counter_pkg` holds two things:
  - the `clog2`-based width function for the prescaler;
  - the constants for the direction encoding (DIR_UP=1, DIR_DOWN=0).
- Sub-module `counter_prescaler` (parameter PRESCALE; ports clk, reset, enable, clr, tick). It is generated as tick=enable when PRESCALE==1. Its clr input is clear|load.
- The top level contains the count register, next-state mux, tc/carry logic and the wrapped register.

## Test plan
- Reset, then WIDTH=4, MODULUS=10, up=1, enable=1 for 12 cycles -> count 0..9, then 0, 1. tc is high while count=9. wrapped pulses once, in the cycle count=0.
- Same configuration with saturate=1 -> count reaches 9 and holds. wrapped pulses every cycle after that.
- Load 7, then up=0 for 9 cycles -> 7..0, 9, 8. Load 15 -> count=9 (clamped).
- PRESCALE=3, enable toggled 0/1 every 4 cycles -> count advances once per 3 enabled cycles. Count and prescaler freeze while enable=0.
- Mid-count reset=0 with load=1 and clear=1 asserted at the same time -> count=0 and wrapped=0. clear+load together -> count=0.
- Two instances cascaded (MODULUS=10, enable of the upper stage = carry_out of the lower) for 25 steps -> upper=2, lower=5. The upper stage steps on the same edge as the lower stage's 9→0 transition.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised counter family.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Prescaler register width; a divide-by-one prescaler still gets one bit.
    function automatic int prescale_width(input int prescale);
        return (prescale <= 1) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable-gated divide-by-PRESCALE strobe generator.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clr,
    output logic tick
);

    if (PRESCALE == 1) begin : g_bypass
        logic unused_inputs;
        assign unused_inputs = &{1'b0, clk, reset, clr};
        assign tick = enable;
    end else begin : g_divide
        localparam int PW = prescale_width(PRESCALE);
        localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

        logic [PW-1:0] psc_q;
        logic [PW-1:0] psc_d;

        assign tick = enable && (psc_q == LAST);

        always_comb begin
            psc_d = psc_q;
            if (clr) begin
                psc_d = '0;
            end else if (enable) begin
                psc_d = (psc_q == LAST) ? '0 : psc_q + PW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                psc_q <= '0;
            end else begin
                psc_q <= psc_d;
            end
        end
    end

endmodule

// File: rtl/param_counter.sv
// Modulo-N up/down counter with prescaler, clear, load, wrap/saturate and cascade outputs.
module param_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 2**WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up,
    input  logic             saturate,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             carry_out,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrapped_q;
    logic             wrapped_d;
    logic             tick;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clr    (clear | load),
        .tick   (tick)
    );

    always_comb begin
        if (up == DIR_DOWN) begin
            tc = (count_q == '0);
        end else begin
            tc = (count_q == COUNT_MAX);
        end
    end

    assign carry_out = tc & enable & tick;

    // Terminal steps are handled explicitly so MODULUS below 2**WIDTH wraps correctly.
    always_comb begin
        count_d   = count_q;
        wrapped_d = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_value > COUNT_MAX) ? COUNT_MAX : load_value;
        end else if (tick) begin
            if (tc) begin
                wrapped_d = 1'b1;
                if (!saturate) begin
                    count_d = (up == DIR_UP) ? '0 : COUNT_MAX;
                end
            end else begin
                count_d = (up == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign count   = count_q;
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench: four counters (plain, prescaled, cascaded pair) against an arithmetic model.
module tb_param_counter;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       reset, clear, load, up, saturate;
    logic       en_a, en_b, en_lo;
    logic [3:0] load_value;

    logic [3:0] cnt_o [4];
    logic       tc_o  [4];
    logic       cy_o  [4];
    logic       wr_o  [4];

    always #5 clk = ~clk;

    param_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .clear(clear), .load(load),
        .load_value(load_value), .up(up), .saturate(saturate),
        .count(cnt_o[0]), .tc(tc_o[0]), .carry_out(cy_o[0]), .wrapped(wr_o[0]));

    param_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(3)) dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .clear(clear), .load(load),
        .load_value(load_value), .up(up), .saturate(saturate),
        .count(cnt_o[1]), .tc(tc_o[1]), .carry_out(cy_o[1]), .wrapped(wr_o[1]));

    param_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(1)) dut_lo (
        .clk(clk), .reset(reset), .enable(en_lo), .clear(clear), .load(load),
        .load_value(load_value), .up(up), .saturate(saturate),
        .count(cnt_o[2]), .tc(tc_o[2]), .carry_out(cy_o[2]), .wrapped(wr_o[2]));

    param_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(1)) dut_hi (
        .clk(clk), .reset(reset), .enable(cy_o[2]), .clear(clear), .load(load),
        .load_value(load_value), .up(up), .saturate(saturate),
        .count(cnt_o[3]), .tc(tc_o[3]), .carry_out(cy_o[3]), .wrapped(wr_o[3]));

    typedef struct packed {
        logic [3:0][3:0] cnt;
        logic [3:0]      wr;
        logic [3:0]      tc;
        logic [3:0]      cy;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cycle_no = 0;

    int m_cnt [4];
    int m_psc [4];
    bit m_wr  [4];
    int P     [4] = '{1, 3, 1, 1};

    function automatic bit m_tc(int i, bit u);
        return u ? (m_cnt[i] == M - 1) : (m_cnt[i] == 0);
    endfunction

    function automatic bit m_carry(int i, bit en, bit u);
        return en && m_tc(i, u) && (m_psc[i] == P[i] - 1);
    endfunction

    function automatic void m_step(int i, bit en, bit r, bit c, bit l, int lv, bit u, bit s);
        bit at_tc;
        bit tk;
        at_tc = m_tc(i, u);
        tk    = en && (m_psc[i] == P[i] - 1);
        if (!r || c) begin
            m_cnt[i] = 0; m_psc[i] = 0; m_wr[i] = 0;
        end else if (l) begin
            m_cnt[i] = (lv > M - 1) ? M - 1 : lv; m_psc[i] = 0; m_wr[i] = 0;
        end else if (en) begin
            m_wr[i] = tk && at_tc;
            if (tk && !(at_tc && s))
                m_cnt[i] = (m_cnt[i] + (u ? 1 : M - 1)) % M;
            m_psc[i] = (m_psc[i] + 1) % P[i];
        end else begin
            m_wr[i] = 0;
        end
    endfunction

    task automatic check(string name, int idx, int act, int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s[%0d] cycle %0d: got %0d, expected %0d", name, idx, cycle_no, act, req);
    endtask

    // Inputs are applied on the falling edge; the expected post-edge state is queued.
    task automatic cyc(bit r, bit c, bit l, int lv, bit u, bit s, bit ea, bit eb, bit el);
        exp_t e;
        bit   eh;
        reset = r; clear = c; load = l; load_value = lv[3:0];
        up = u; saturate = s; en_a = ea; en_b = eb; en_lo = el;
        eh = m_carry(2, el, u);
        m_step(0, ea, r, c, l, lv, u, s);
        m_step(1, eb, r, c, l, lv, u, s);
        m_step(2, el, r, c, l, lv, u, s);
        m_step(3, eh, r, c, l, lv, u, s);
        for (int i = 0; i < 4; i++) begin
            e.cnt[i] = m_cnt[i][3:0];
            e.wr[i]  = m_wr[i];
            e.tc[i]  = m_tc(i, u);
        end
        e.cy[0] = m_carry(0, ea, u);
        e.cy[1] = m_carry(1, eb, u);
        e.cy[2] = m_carry(2, el, u);
        e.cy[3] = m_carry(3, m_carry(2, el, u), u);
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < 4; i++) begin
                    check("count",     i, int'(cnt_o[i]), int'(e.cnt[i]));
                    check("wrapped",   i, int'(wr_o[i]),  int'(e.wr[i]));
                    check("tc",        i, int'(tc_o[i]),  int'(e.tc[i]));
                    check("carry_out", i, int'(cy_o[i]),  int'(e.cy[i]));
                end
            end
        end
    end

    initial begin : driver
        bit s_r;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_psc[i] = 0; m_wr[i] = 0;
        end
        reset = 0; clear = 0; load = 0; load_value = 0; up = 1; saturate = 0;
        en_a = 0; en_b = 0; en_lo = 0;
        @(negedge clk);

        repeat (2) cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
        // count 0..9, wrap to 0, 1
        repeat (12) cyc(1, 0, 0, 0, 1, 0, 1, 1, 1);
        // saturating at 9
        cyc(1, 1, 0, 0, 1, 1, 1, 1, 1);
        repeat (12) cyc(1, 0, 0, 0, 1, 1, 1, 1, 1);
        // load 7, count down through wrap, then clamped load
        cyc(1, 0, 1, 7, 0, 0, 1, 1, 1);
        repeat (9) cyc(1, 0, 0, 0, 0, 0, 1, 1, 1);
        cyc(1, 0, 1, 15, 0, 0, 1, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // prescaled counter with enable toggling every 4 cycles
        cyc(1, 1, 0, 0, 1, 0, 1, 0, 1);
        for (int k = 0; k < 24; k++) cyc(1, 0, 0, 0, 1, 0, 1, ((k / 4) % 2) == 1, 1);
        // reset wins over clear and load; clear wins over load
        repeat (5) cyc(1, 0, 0, 0, 1, 0, 1, 1, 1);
        cyc(0, 1, 1, 6, 1, 0, 1, 1, 1);
        repeat (3) cyc(1, 0, 0, 0, 1, 0, 1, 1, 1);
        cyc(1, 1, 1, 6, 1, 0, 1, 1, 1);
        // cascade: 25 steps -> hi=2, lo=5
        cyc(1, 1, 0, 0, 1, 0, 0, 0, 0);
        repeat (25) cyc(1, 0, 0, 0, 1, 0, 0, 0, 1);
        check("cascade_lo", 2, int'(cnt_o[2]), 5);
        check("cascade_hi", 3, int'(cnt_o[3]), 2);
        // randomized traffic
        s_r = 0;
        for (int k = 0; k < 400; k++) begin
            if (k % 16 == 0) s_r = $urandom_range(0, 1) == 1;
            cyc($urandom_range(0, 39) != 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
                $urandom_range(0, 3) != 0, s_r,
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 4) != 0);
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 0, sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
